// File: rtl/pmu_ahb_pkg.sv
// Shared AHB encodings and the master FSM state type for pmu_ahb_master.
package pmu_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] HRESP_RETRY   = 2'b10;
    localparam logic [1:0] HRESP_SPLIT   = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_ERR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/pmu_ahb_master_wdog.sv
// Data-phase watchdog: flags the cycle that completes TIMEOUT_CYCLES consecutive stalls.
module pmu_ahb_master_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic i_en,
    input  logic i_hready,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          w_stall;

    assign w_stall  = i_en && !i_hready;
    assign o_expire = w_stall && (r_cnt == LAST);

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_cnt <= '0;
        end else if (w_stall && !o_expire) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
        end
    end

endmodule

// File: rtl/pmu_ahb_master.sv
// Single-transfer AHB master with RETRY/SPLIT re-issue.
// Optional data-phase timeout enabled by PMU_AHB_MASTER_TIMEOUT_EN.
module pmu_ahb_master
    import pmu_ahb_pkg::*;
#(
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned MAX_RETRY      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_write_i,
    input  logic [REG_WIDTH-1:0] req_addr_i,
    input  logic [REG_WIDTH-1:0] req_wdata_i,
    output logic                 rsp_valid_o,
    output logic [REG_WIDTH-1:0] rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o,
    output logic [REG_WIDTH-1:0] haddr_o,
    output logic                 hwrite_o,
    output logic [1:0]           htrans_o,
    output logic [2:0]           hsize_o,
    output logic [2:0]           hburst_o,
    output logic [REG_WIDTH-1:0] hwdata_o,
    input  logic                 hready_i,
    input  logic [1:0]           hresp_i,
    input  logic [REG_WIDTH-1:0] hrdata_i
);

    localparam int unsigned RW = $clog2(MAX_RETRY + 2);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [REG_WIDTH-1:0] r_addr;
    logic [REG_WIDTH-1:0] r_wdata;
    logic                 r_write;
    logic [RW-1:0]        r_retry;
    logic [REG_WIDTH-1:0] r_rsp_rdata;
    logic                 r_rsp_err;
    logic                 w_rsp_load;
    logic                 w_err_nxt;
    logic                 w_retry_inc;
    logic                 w_is_retry;

`ifdef PMU_AHB_MASTER_TIMEOUT_EN
    logic w_expire;
    logic w_to_nxt;
    logic r_rsp_to;

    pmu_ahb_master_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .i_en     ((r_state == ST_DATA) || (r_state == ST_ERR)),
        .i_hready (hready_i),
        .o_expire (w_expire)
    );

    assign rsp_timeout_o = r_rsp_to;
`else
    assign rsp_timeout_o = 1'b0;
`endif

    assign w_is_retry = (hresp_i == HRESP_RETRY) || (hresp_i == HRESP_SPLIT);

    always_comb begin
        w_state_nxt = r_state;
        w_rsp_load  = 1'b0;
        w_err_nxt   = 1'b0;
        w_retry_inc = 1'b0;
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
        w_to_nxt    = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (req_valid_i) w_state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                if (hready_i) w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
                if (w_expire) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_to_nxt    = 1'b1;
                end else
`endif
                // Non-OKAY with hready high skips the first response cycle: treat as ERROR.
                if (hready_i) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_err_nxt   = (hresp_i != HRESP_OKAY);
                end else if (hresp_i != HRESP_OKAY) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
                if (w_expire) begin
                    w_state_nxt = ST_RESP;
                    w_rsp_load  = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_to_nxt    = 1'b1;
                end else
`endif
                if (hready_i) begin
                    if (w_is_retry && (r_retry < RETRY_LIMIT)) begin
                        w_retry_inc = 1'b1;
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_rsp_load  = 1'b1;
                        w_err_nxt   = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_retry     <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
            r_rsp_to    <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && req_valid_i) begin
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_write <= req_write_i;
            end
            if (r_state == ST_RESP) begin
                r_retry <= '0;
            end else if (w_retry_inc) begin
                r_retry <= r_retry + RW'(1);
            end
            if (w_rsp_load) begin
                r_rsp_rdata <= (!w_err_nxt && !r_write) ? hrdata_i : '0;
                r_rsp_err   <= w_err_nxt;
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
                r_rsp_to    <= w_to_nxt;
`endif
            end
        end
    end

    assign req_ready_o = (r_state == ST_IDLE);
    assign rsp_valid_o = (r_state == ST_RESP);
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign haddr_o     = r_addr;
    assign hwrite_o    = r_write;
    assign htrans_o    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign hsize_o     = HSIZE_WORD;
    assign hburst_o    = HBURST_SINGLE;
    assign hwdata_o    = r_wdata;

endmodule

// File: tb/tb_pmu_ahb_master.sv
// Directed self-checking bench for pmu_ahb_master (default or PMU_AHB_MASTER_TIMEOUT_EN build).
module tb_pmu_ahb_master;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic [31:0] haddr_o;
    logic        hwrite_o;
    logic [1:0]  htrans_o;
    logic [2:0]  hsize_o;
    logic [2:0]  hburst_o;
    logic [31:0] hwdata_o;
    logic        hready_i;
    logic [1:0]  hresp_i;
    logic [31:0] hrdata_i;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    pmu_ahb_master #(
        .REG_WIDTH      (32),
        .MAX_RETRY      (4),
        .TIMEOUT_CYCLES (255)
    ) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_write_i   (req_write_i),
        .req_addr_i    (req_addr_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .rsp_timeout_o (rsp_timeout_o),
        .haddr_o       (haddr_o),
        .hwrite_o      (hwrite_o),
        .htrans_o      (htrans_o),
        .hsize_o       (hsize_o),
        .hburst_o      (hburst_o),
        .hwdata_o      (hwdata_o),
        .hready_i      (hready_i),
        .hresp_i       (hresp_i),
        .hrdata_i      (hrdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Present a command for one edge; on return the DUT is in ADDR.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid_i = 1'b1;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        tick();
        req_valid_i = 1'b0;
    endtask

    initial begin
        int n_ns;
        int first_rsp;
        logic to_at, err_at;

        rstn_i      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        hready_i    = 1'b1;
        hresp_i     = 2'b00;
        hrdata_i    = '0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",   req_ready_o,   1);
        chk("rst_hsize",   hsize_o,       3'b010);
        chk("rst_hburst",  hburst_o,      0);
        chk("rst_htrans",  htrans_o,      0);
        chk("rst_rspv",    rsp_valid_o,   0);
        chk("rst_err",     rsp_err_o,     0);
        chk("rst_to",      rsp_timeout_o, 0);
        chk("rst_rdata",   rsp_rdata_o,   0);
        chk("rst_haddr",   haddr_o,       0);
        chk("rst_hwdata",  hwdata_o,      0);
        rstn_i = 1'b1;
        tick();

        // Zero-wait write: NONSEQ at T+1, data at T+2, response at T+3
        issue(1'b1, 32'h8010_0000, 32'hCAFE_CAFE);
        chk("wr_htrans_a", htrans_o, 2'b10);
        chk("wr_haddr",    haddr_o,  32'h8010_0000);
        chk("wr_hwrite",   hwrite_o, 1);
        chk("wr_ready_a",  req_ready_o, 0);
        tick();
        chk("wr_htrans_d", htrans_o, 2'b00);
        chk("wr_hwdata",   hwdata_o, 32'hCAFE_CAFE);
        chk("wr_rspv_d",   rsp_valid_o, 0);
        tick();
        chk("wr_rspv",     rsp_valid_o, 1);
        chk("wr_err",      rsp_err_o, 0);
        chk("wr_rdata",    rsp_rdata_o, 0);
        tick();
        chk("wr_rspv_off", rsp_valid_o, 0);
        chk("wr_ready_i",  req_ready_o, 1);

        // Read with 3 wait states; a second command held meanwhile must be ignored
        issue(1'b0, 32'h8010_00AC, 32'h0);
        chk("rd_htrans_a", htrans_o, 2'b10);
        chk("rd_hwrite",   hwrite_o, 0);
        tick();
        req_valid_i = 1'b1;
        req_addr_i  = 32'h9999_0000;
        hready_i    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rd_wait_htrans", htrans_o, 0);
            chk("rd_wait_rspv",   rsp_valid_o, 0);
        end
        hready_i = 1'b1;
        hrdata_i = 32'h1234_5678;
        tick();
        req_valid_i = 1'b0;
        chk("rd_rspv",  rsp_valid_o, 1);
        chk("rd_rdata", rsp_rdata_o, 32'h1234_5678);
        chk("rd_err",   rsp_err_o, 0);
        hrdata_i = 32'hDEAD_BEEF;
        tick();
        chk("rd_hold_rdata", rsp_rdata_o, 32'h1234_5678);
        chk("rd_haddr_kept", haddr_o, 32'h8010_00AC);
        tick();
        chk("rd_no_queue", htrans_o, 0);

        // Two-cycle ERROR on a write
        issue(1'b1, 32'h8010_0004, 32'h0000_00FF);
        tick();
        hready_i = 1'b0;
        hresp_i  = 2'b01;
        tick();
        chk("err_first_rspv", rsp_valid_o, 0);
        chk("err_first_htr",  htrans_o, 0);
        hready_i = 1'b1;
        tick();
        hresp_i = 2'b00;
        chk("err_rspv",  rsp_valid_o, 1);
        chk("err_err",   rsp_err_o, 1);
        chk("err_rdata", rsp_rdata_o, 0);
        tick();
        chk("err_rspv_off", rsp_valid_o, 0);
        chk("err_hold",     rsp_err_o, 1);
        tick();
        chk("err_no_reissue", htrans_o, 0);

        // Non-OKAY with hready high in DATA is handled as ERROR
        issue(1'b0, 32'h8010_0008, 32'h0);
        tick();
        hresp_i  = 2'b10;
        hrdata_i = 32'hFFFF_FFFF;
        tick();
        hresp_i = 2'b00;
        chk("viol_rspv",  rsp_valid_o, 1);
        chk("viol_err",   rsp_err_o, 1);
        chk("viol_rdata", rsp_rdata_o, 0);
        tick();

        // RETRY five times with MAX_RETRY=4: original issue plus 4 re-issues
        issue(1'b1, 32'h8010_000C, 32'h5555_AAAA);
        n_ns = 0;
        for (int i = 0; i < 5; i++) begin
            if (htrans_o == 2'b10) n_ns++;
            hready_i = 1'b1;
            hresp_i  = 2'b00;
            tick();
            hready_i = 1'b0;
            hresp_i  = 2'b10;
            tick();
            hready_i = 1'b1;
            tick();
        end
        hresp_i = 2'b00;
        chk("retry5_nonseq", n_ns, 5);
        chk("retry5_rspv",   rsp_valid_o, 1);
        chk("retry5_err",    rsp_err_o, 1);
        tick();

        // RETRY twice then OKAY on a read
        issue(1'b0, 32'h8010_0010, 32'h0);
        for (int i = 0; i < 2; i++) begin
            chk("retry2_nonseq", htrans_o, 2'b10);
            hready_i = 1'b1;
            hresp_i  = 2'b00;
            tick();
            hready_i = 1'b0;
            hresp_i  = 2'b11;
            tick();
            hready_i = 1'b1;
            tick();
        end
        hresp_i = 2'b00;
        chk("retry2_nonseq3", htrans_o, 2'b10);
        tick();
        hrdata_i = 32'h5A5A_1234;
        tick();
        chk("retry2_rspv",  rsp_valid_o, 1);
        chk("retry2_err",   rsp_err_o, 0);
        chk("retry2_rdata", rsp_rdata_o, 32'h5A5A_1234);
        tick();

        // hready held low 300 cycles in DATA
        issue(1'b0, 32'h8010_0020, 32'h0);
        tick();
        hready_i  = 1'b0;
        first_rsp = -1;
        to_at     = 1'b0;
        err_at    = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (rsp_valid_o && first_rsp < 0) begin
                first_rsp = i;
                to_at     = rsp_timeout_o;
                err_at    = rsp_err_o;
            end
        end
`ifdef PMU_AHB_MASTER_TIMEOUT_EN
        chk("to_cycle", first_rsp, 255);
        chk("to_err",   err_at, 1);
        chk("to_flag",  to_at, 1);
`else
        chk("to_none",     first_rsp, 32'hFFFF_FFFF);
        chk("to_flag_off", rsp_timeout_o, 0);
        chk("to_busy",     req_ready_o, 0);
`endif
        hready_i = 1'b1;
        tick();
        tick();
        chk("to_idle", req_ready_o, 1);

        // Synchronous reset in the middle of a data phase
        issue(1'b1, 32'h8010_0030, 32'h1111_2222);
        tick();
        hready_i = 1'b0;
        chk("mid_in_data", hwdata_o, 32'h1111_2222);
        rstn_i = 1'b0;
        tick();
        chk("mid_htrans", htrans_o, 0);
        chk("mid_ready",  req_ready_o, 1);
        chk("mid_rspv",   rsp_valid_o, 0);
        chk("mid_hwdata", hwdata_o, 0);
        rstn_i   = 1'b1;
        hready_i = 1'b1;
        tick();
        chk("mid_rspv_after", rsp_valid_o, 0);
        chk("mid_err_clear",  rsp_err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
